alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Arbitrates one shared 32-bit ALU between two requesters: requester 0 is the main execute path, requester 1 is the address/branch-compare path.
- Round-robin arbitration; valid/ready handshake on each request port.
- Instantiates one ALU (combinational) and registers its result and zero flag in a single-entry output stage; the response is routed back to the winning requester.
- Per-requester saturating grant counters are provided for performance visibility.

Parameters:
- P_RST_PRIO, 0: requester holding priority after reset (0 or 1).
- P_CNT_W, 16: width of each grant counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  2  bit k: requester k presents an operation.
- o_req_ready  out  2  bit k: requester k's operation is accepted this cycle.
- i_req0_op, i_req1_op  in  4 each  ALU control code (ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101).
- i_req0_a, i_req0_b, i_req1_a, i_req1_b  in  32 each  operands.
- o_rsp_valid  out  2  bit k: response for requester k is held in the output stage.
- i_rsp_ready  in  2  bit k: requester k consumes its response.
- o_rsp_result  out  32  registered ALU result, shared by both requesters.
- o_rsp_zero  out  1  registered zero flag, shared by both requesters.
- o_grant_cnt0, o_grant_cnt1  out  P_CNT_W each  accepted-request counts.

Behaviour:
- Reset (i_rst_n=0 at edge):
  - stage_valid=0, so o_rsp_valid=00.
  - o_rsp_result=0, o_rsp_zero=0.
  - Priority pointer = P_RST_PRIO.
  - Both counters = 0.
  - Reset mid-operation discards the held response and any in-flight grant; no response is produced for it.
- While i_rst_n=0, o_req_ready=00 (combinational gating).
- Output stage:
  - stage_free = !stage_valid || i_rsp_ready[stage_id].
  - The i_rsp_ready bit of the requester that does not own the stage is ignored.
- Grant (combinational):
  - If stage_free is 0, there is no grant and o_req_ready=00.
  - Else, if exactly one i_req_valid bit is set, that requester is granted.
  - If both are set, the requester named by the priority pointer is granted.
  - o_req_ready is one-hot or zero and is never asserted to a requester whose valid is low.
- Accept:
  - A transfer occurs when i_req_valid[k] && o_req_ready[k].
  - Next cycle: stage_valid=1, stage_id=k, o_rsp_result=ALU(op_k,a_k,b_k), o_rsp_zero=(result==0).
  - Latency is exactly 1 cycle from accept to o_rsp_valid.
- Priority pointer:
  - After any accept by requester k, the pointer becomes 1-k.
  - With no accept, the pointer is unchanged.
  - Under continuous dual requests, grants strictly alternate.
- Drain:
  - If i_rsp_ready[stage_id] is high and there is no new accept, stage_valid=0 next cycle.
  - Simultaneous drain and accept: the new response replaces the old one with no bubble, giving full throughput of 1 op/cycle.
- Hold:
  - While o_rsp_valid[k] is high and i_rsp_ready[k] is low, o_rsp_result, o_rsp_zero and stage_id are stable.
  - In that state no new accept occurs, for either requester.
- Requester obligations: a requester holding valid without ready must keep op, a and b stable. The block does not check this.
- Unsupported opcodes are accepted normally: the response is result=0, zero=1.
- SLT compares unsigned, as the ALU does.
- Counters increment by 1 on each accept by their requester and saturate at all-ones; they do not wrap.
- o_rsp_valid = stage_valid ? (stage_id ? 10 : 01) : 00.

Test Plan:
- Reset then single request: P_RST_PRIO=0. Req0 valid with ADD, a=5, b=7, i_rsp_ready=11.
  -> o_req_ready=01 the same cycle; next cycle o_rsp_valid=01, result=12, zero=0; o_grant_cnt0=1.
- Contention alternation: both valid continuously for 4 cycles (req0 SUB 9-9, req1 OR 0xF0|0x0F), rsp_ready=11.
  -> grant order 0,1,0,1.
  -> responses alternate: (01, result 0, zero 1) and (10, result 0xFF, zero 0).
  -> both counters = 2; no idle cycles.
- Backpressure: req1 SLT a=3, b=8 accepted; hold i_rsp_ready[1]=0 for 3 cycles while req0 stays valid.
  -> o_rsp_valid=10, result=1 stable for those cycles; o_req_ready=00.
  -> when rsp_ready[1]=1, req0 is accepted the same cycle.
- Drain plus accept: hold stage occupied by req0, assert i_rsp_ready[0]=1 and req1 valid AND a=0xFFFF0000, b=0x0000FFFF.
  -> next cycle o_rsp_valid=10, result=0, zero=1 (no bubble).
- Reset mid-operation: response held with rsp_ready=0; pulse i_rst_n=0 for 1 cycle.
  -> o_rsp_valid=00, result=0, counters=0, pointer=P_RST_PRIO; the held response never reappears.
- Counter saturation with P_CNT_W=4: 20 accepts from req0.
  -> o_grant_cnt0=15 (stays); invalid opcode 1111 gives result=0, zero=1.

Source files
------------

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one 32-bit ALU between two requesters
module alu_share_arb #(
    parameter logic       P_RST_PRIO = 1'b0,
    parameter int         P_CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [3:0]         i_req0_op,
    input  logic [31:0]        i_req0_a,
    input  logic [31:0]        i_req0_b,
    input  logic [3:0]         i_req1_op,
    input  logic [31:0]        i_req1_a,
    input  logic [31:0]        i_req1_b,
    output logic [1:0]         o_rsp_valid,
    input  logic [1:0]         i_rsp_ready,
    output logic [31:0]        o_rsp_result,
    output logic               o_rsp_zero,
    output logic [P_CNT_W-1:0] o_grant_cnt0,
    output logic [P_CNT_W-1:0] o_grant_cnt1
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0101;

    localparam logic [P_CNT_W-1:0] CNT_MAX = {P_CNT_W{1'b1}};
    localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

    logic               stage_valid;
    logic               stage_id;
    logic               prio;
    logic [31:0]        result_q;
    logic               zero_q;
    logic [P_CNT_W-1:0] cnt0;
    logic [P_CNT_W-1:0] cnt1;

    logic               stage_free;
    logic [1:0]         grant;
    logic               grant_id;
    logic [3:0]         alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_y;

    // Grant: the stage must be empty or draining this cycle; ties go to the priority pointer.
    always_comb begin
        stage_free = !stage_valid || i_rsp_ready[stage_id];
        grant      = 2'b00;
        if (i_rst_n && stage_free) begin
            case (i_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        grant_id = grant[1];
    end

    // Operand mux and the shared combinational ALU; unknown opcodes yield zero.
    always_comb begin
        alu_op = grant_id ? i_req1_op : i_req0_op;
        alu_a  = grant_id ? i_req1_a  : i_req0_a;
        alu_b  = grant_id ? i_req1_b  : i_req0_b;
        alu_y  = 32'd0;
        case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_SLT:  alu_y = {31'd0, (alu_a < alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    // Output stage: load on accept, clear on drain, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stage_valid <= 1'b0;
            stage_id    <= 1'b0;
            result_q    <= 32'd0;
            zero_q      <= 1'b0;
        end else if (grant != 2'b00) begin
            stage_valid <= 1'b1;
            stage_id    <= grant_id;
            result_q    <= alu_y;
            zero_q      <= (alu_y == 32'd0);
        end else if (stage_valid && i_rsp_ready[stage_id]) begin
            stage_valid <= 1'b0;
        end
    end

    // Round-robin pointer: after an accept the other requester gets priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prio <= P_RST_PRIO;
        end else if (grant != 2'b00) begin
            prio <= !grant_id;
        end
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant[0] && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_ONE;
            if (grant[1] && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_ONE;
        end
    end

    assign o_req_ready  = grant;
    assign o_rsp_valid  = stage_valid ? (stage_id ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_result = result_q;
    assign o_rsp_zero   = zero_q;
    assign o_grant_cnt0 = cnt0;
    assign o_grant_cnt1 = cnt1;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb
module tb_alu_share_arb;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    op0, op1;
    logic [31:0]   a0, b0, a1, b1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_zero;
    logic [CW-1:0] cnt0, cnt1;

    int nvec = 0;
    int nfail = 0;

    // reference model state
    bit          m_valid;
    int          m_id;
    logic [31:0] m_res;
    bit          m_zero;
    int          m_prio;
    int          m_cnt [2];

    alu_share_arb #(.P_RST_PRIO(1'b0), .P_CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero),
        .o_grant_cnt0(cnt0), .o_grant_cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_ready();
        bit free;
        if (!rst_n) return 2'b00;
        free = !m_valid || rsp_ready[m_id];
        if (!free) return 2'b00;
        if (req_valid == 2'b11) return (m_prio == 1) ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    function automatic logic [1:0] exp_rsp_valid();
        if (!m_valid) return 2'b00;
        return (m_id == 1) ? 2'b10 : 2'b01;
    endfunction

    // advance one clock, updating the model with the inputs present at the edge
    task automatic tick();
        logic [1:0] acc;
        int k;
        acc = exp_ready();
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_prio = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (acc != 2'b00) begin
            k = acc[1] ? 1 : 0;
            m_valid = 1;
            m_id = k;
            m_res = (k == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            m_zero = (m_res == 32'd0);
            m_prio = 1 - k;
            if (m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
        end else if (m_valid && rsp_ready[m_id]) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        op0 = 4'd0; a0 = 32'd1; b0 = 32'd1;
        op1 = 4'd0; a1 = 32'd2; b1 = 32'd2;
        #1;
        nvec++;
        if (req_ready !== 2'b00) begin nfail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        tick();
        nvec++;
        if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        nvec++;
        if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin nfail++; $display("FAIL reset_result got=%h/%b exp=0/0", rsp_result, rsp_zero); end
        nvec++;
        if (cnt0 !== 0 || cnt1 !== 0) begin nfail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        rst_n = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01; op0 = 4'd0; a0 = 32'd5; b0 = 32'd7; rsp_ready = 2'b11;
        #1;
        nvec++;
        if (req_ready !== 2'b01) begin nfail++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        nvec++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0)
            begin nfail++; $display("FAIL single_rsp got=%b/%0d/%b exp=01/12/0", rsp_valid, rsp_result, rsp_zero); end
        nvec++;
        if (cnt0 !== 4'd1) begin nfail++; $display("FAIL single_cnt0 got=%0d exp=1", cnt0); end
    endtask

    task automatic test_alternation();
        logic [1:0] exp_g;
        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        op0 = 4'd1; a0 = 32'd9; b0 = 32'd9;
        op1 = 4'd3; a1 = 32'hF0; b1 = 32'h0F;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            nvec++;
            if (req_ready !== exp_g) begin nfail++; $display("FAIL alt_grant%0d got=%b exp=%b", i, req_ready, exp_g); end
            tick();
            nvec++;
            if (exp_g == 2'b01) begin
                if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
                    begin nfail++; $display("FAIL alt_rsp%0d got=%b/%h/%b exp=01/0/1", i, rsp_valid, rsp_result, rsp_zero); end
            end else begin
                if (rsp_valid !== 2'b10 || rsp_result !== 32'hFF || rsp_zero !== 1'b0)
                    begin nfail++; $display("FAIL alt_rsp%0d got=%b/%h/%b exp=10/ff/0", i, rsp_valid, rsp_result, rsp_zero); end
            end
        end
        req_valid = 2'b00;
        nvec++;
        if (cnt0 !== 4'd2 || cnt1 !== 4'd2) begin nfail++; $display("FAIL alt_cnt got=%0d/%0d exp=2/2", cnt0, cnt1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 2'b10; op1 = 4'd5; a1 = 32'd3; b1 = 32'd8; rsp_ready = 2'b11;
        #1;
        nvec++;
        if (req_ready !== 2'b10) begin nfail++; $display("FAIL bp_accept got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b01; op0 = 4'd0; a0 = 32'd40; b0 = 32'd2; rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++;
            if (req_ready !== 2'b00) begin nfail++; $display("FAIL bp_ready%0d got=%b exp=00", i, req_ready); end
            nvec++;
            if (rsp_valid !== 2'b10 || rsp_result !== 32'd1 || rsp_zero !== 1'b0)
                begin nfail++; $display("FAIL bp_hold%0d got=%b/%0d/%b exp=10/1/0", i, rsp_valid, rsp_result, rsp_zero); end
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        nvec++;
        if (req_ready !== 2'b01) begin nfail++; $display("FAIL bp_release got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        nvec++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd42) begin nfail++; $display("FAIL bp_next got=%b/%0d exp=01/42", rsp_valid, rsp_result); end
    endtask

    task automatic test_drain_accept();
        do_reset();
        req_valid = 2'b01; op0 = 4'd0; a0 = 32'd1; b0 = 32'd2; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b01;
        req_valid = 2'b10; op1 = 4'd2; a1 = 32'hFFFF0000; b1 = 32'h0000FFFF;
        #1;
        nvec++;
        if (req_ready !== 2'b10) begin nfail++; $display("FAIL drain_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        nvec++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            begin nfail++; $display("FAIL drain_rsp got=%b/%h/%b exp=10/0/1", rsp_valid, rsp_result, rsp_zero); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 2'b10; op1 = 4'd0; a1 = 32'd100; b1 = 32'd1; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || cnt0 !== 0 || cnt1 !== 0)
                begin nfail++; $display("FAIL midrst%0d got=%b/%h/%0d/%0d exp=00/0/0/0", i, rsp_valid, rsp_result, cnt0, cnt1); end
            tick();
        end
        req_valid = 2'b11; op0 = 4'd0; a0 = 0; b0 = 0; op1 = 4'd0; a1 = 0; b1 = 0;
        #1;
        nvec++;
        if (req_ready !== 2'b01) begin nfail++; $display("FAIL midrst_prio got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        for (int i = 0; i < 20; i++) begin
            op0 = (i == 19) ? 4'hF : 4'd0;
            a0 = 32'd7; b0 = 32'd1;
            tick();
        end
        req_valid = 2'b00;
        nvec++;
        if (cnt0 !== 4'd15) begin nfail++; $display("FAIL sat_cnt0 got=%0d exp=15", cnt0); end
        nvec++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            begin nfail++; $display("FAIL sat_badop got=%b/%h/%b exp=01/0/1", rsp_valid, rsp_result, rsp_zero); end
        tick();
        nvec++;
        if (cnt0 !== 4'd15) begin nfail++; $display("FAIL sat_hold got=%0d exp=15", cnt0); end
    endtask

    task automatic test_random();
        logic [3:0] ops [7];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'hF};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            op0 = ops[$urandom_range(0, 6)];
            op1 = ops[$urandom_range(0, 6)];
            a0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            a1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            b1 = ($urandom_range(0, 3) == 0) ? a1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            #1;
            nvec++;
            if (req_ready !== exp_ready()) begin nfail++; $display("FAIL rnd_ready%0d got=%b exp=%b", i, req_ready, exp_ready()); end
            tick();
            nvec++;
            if (rsp_valid !== exp_rsp_valid()) begin nfail++; $display("FAIL rnd_rsp_valid%0d got=%b exp=%b", i, rsp_valid, exp_rsp_valid()); end
            nvec++;
            if (rsp_result !== m_res || rsp_zero !== m_zero)
                begin nfail++; $display("FAIL rnd_result%0d got=%h/%b exp=%h/%b", i, rsp_result, rsp_zero, m_res, m_zero); end
            nvec++;
            if (int'(cnt0) != m_cnt[0] || int'(cnt1) != m_cnt[1])
                begin nfail++; $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", i, cnt0, cnt1, m_cnt[0], m_cnt[1]); end
        end
        rst_n = 1'b1;
        req_valid = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
        op0 = 0; a0 = 0; b0 = 0; op1 = 0; a1 = 0; b1 = 0;
        m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_prio = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_drain_accept();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
